// File: rtl/cmp_rr_arbiter_pkg.sv
// Shared definitions for the round-robin comparator arbiter: FSM encoding,
// default sizing and the modulo helper used for pointer arithmetic.
package cmp_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 2;

  // Wraps an index that can exceed n by at most n - 1 back into 0..n-1.
  function automatic int rr_wrap(input int idx, input int n);
    if (idx >= n) begin
      return idx - n;
    end else begin
      return idx;
    end
  endfunction

endpackage

// File: rtl/cmp_rr_arbiter_cmp_unit.sv
// Purely combinational unsigned magnitude comparator shared by all requesters.
module cmp_unit
  import cmp_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             g,
  output logic             e,
  output logic             l
);

  assign g = (a > b);
  assign e = (a == b);
  assign l = (a < b);

endmodule

// File: rtl/cmp_rr_arbiter.sv
// Round-robin sequencer granting one requester at a time access to a shared
// comparator; returns registered g/e/l with a done pulse tagged by requester id.
module cmp_rr_arbiter
  import cmp_rr_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_bus,
  input  logic [N_REQ*WIDTH-1:0] b_bus,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   done,
  output logic [ID_W-1:0]        resp_id,
  output logic                   g,
  output logic                   e,
  output logic                   l
);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]    rid_q, rid_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               g_q, g_d, e_q, e_d, l_q, l_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic [WIDTH-1:0]   a_arr_s [N_REQ];
  logic [WIDTH-1:0]   b_arr_s [N_REQ];
  logic               win_found_s;
  logic [ID_W-1:0]    win_idx_s;
  logic [ID_W-1:0]    cand_s;
  logic               cmp_g_s, cmp_e_s, cmp_l_s;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr_s[i] = a_bus[i*WIDTH +: WIDTH];
    assign b_arr_s[i] = b_bus[i*WIDTH +: WIDTH];
  end

  cmp_unit #(.WIDTH(WIDTH)) u_cmp (
    .a (a_q),
    .b (b_q),
    .g (cmp_g_s),
    .e (cmp_e_s),
    .l (cmp_l_s)
  );

  // Priority search: first requester at or after the pointer, wrapping around.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {ID_W{1'b0}};
    cand_s      = {ID_W{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      cand_s = ID_W'(rr_wrap(int'(ptr_q) + k, N_REQ));
      if (!win_found_s && req[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state logic; busy/done are derived from the next state so they are flops.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rid_d   = rid_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    g_d     = g_q;
    e_d     = e_q;
    l_d     = l_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d = ST_EVAL;
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_s;
          rid_d   = win_idx_s;
          a_d     = a_arr_s[win_idx_s];
          b_d     = b_arr_s[win_idx_s];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EVAL: begin
        g_d     = cmp_g_s;
        e_d     = cmp_e_s;
        l_d     = cmp_l_s;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // Moving past the served requester gives it lowest priority next round.
        gnt_d   = {N_REQ{1'b0}};
        ptr_d   = ID_W'(rr_wrap(int'(rid_q) + 1, N_REQ));
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = {N_REQ{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_RESP);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= {N_REQ{1'b0}};
      rid_q   <= {ID_W{1'b0}};
      ptr_q   <= {ID_W{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      g_q     <= 1'b0;
      e_q     <= 1'b0;
      l_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rid_q   <= rid_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      g_q     <= g_d;
      e_q     <= e_d;
      l_q     <= l_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign resp_id = rid_q;
  assign g       = g_q;
  assign e       = e_q;
  assign l       = l_q;

endmodule

// File: tb/tb_cmp_rr_arbiter.sv
// Scoreboard bench for cmp_rr_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares on every done pulse.
module tb_cmp_rr_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 2;
  localparam int ID_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_bus;
  logic [N_REQ*WIDTH-1:0] b_bus;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic                   done;
  logic [ID_W-1:0]        resp_id;
  logic                   g, e, l;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            g;
    logic            e;
    logic            l;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_x;
  logic [N_REQ-1:0] mon_one;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  cmp_rr_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .a_bus   (a_bus),
    .b_bus   (b_bus),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .resp_id (resp_id),
    .g       (g),
    .e       (e),
    .l       (l)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done with id %0d, expected no response", resp_id);
      end else begin
        mon_x   = sb_q.pop_front();
        mon_one = 4'b0001;
        check("resp_id", 32'(resp_id), 32'(mon_x.id));
        check("gel", 32'({g, e, l}), 32'({mon_x.g, mon_x.e, mon_x.l}));
        check("gnt_onehot", 32'(gnt), 32'(mon_one << mon_x.id));
        check("busy_in_resp", 32'(busy), 32'd1);
      end
    end
  end

  task automatic wait_done(output logic [ID_W-1:0] id, output int at_cyc);
    bit seen;
    seen   = 1'b0;
    id     = '0;
    at_cyc = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen   = 1'b1;
        id     = resp_id;
        at_cyc = cyc;
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done in 20 cycles, expected one");
    end
  endtask

  task automatic push_exp(input int idx, input logic eg, input logic ee, input logic el);
    sb_q.push_back({ID_W'(idx), eg, ee, el});
  endtask

  task automatic set_ops(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    a_bus[idx*WIDTH +: WIDTH] = a;
    b_bus[idx*WIDTH +: WIDTH] = b;
  endtask

  // One complete handshake for a single requester.
  task automatic issue(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic eg, input logic ee, input logic el);
    logic [ID_W-1:0] id;
    int c;
    set_ops(idx, a, b);
    push_exp(idx, eg, ee, el);
    req[idx] = 1'b1;
    wait_done(id, c);
    check("handshake_id", 32'(id), 32'(idx));
    req[idx] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [ID_W-1:0] id;
    int c, prev_c;
    logic [ID_W-1:0] rr_ids [5];

    rst   = 1'b1;
    req   = '0;
    a_bus = '0;
    b_bus = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_gel", 32'({g, e, l}), 32'd0);
    rst = 1'b0;

    // Single requester: 2 > 1.
    issue(0, 2'b10, 2'b01, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("hold_gel", 32'({g, e, l}), 32'b100);
    check("hold_done", 32'(done), 32'd0);

    // Reset while a compare is in EVAL.
    set_ops(0, 2'b11, 2'b11);
    req[0] = 1'b1;
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_gel", 32'({g, e, l}), 32'd0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    issue(2, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0);

    // Requester 1 walks every operand pair.
    for (int ai = 0; ai < 4; ai++) begin
      for (int bi = 0; bi < 4; bi++) begin
        issue(1, WIDTH'(ai), WIDTH'(bi), ai > bi, ai == bi, ai < bi);
      end
    end

    // All four requesting: 0,1,2,3,0 with done every 3 cycles.
    pulse_reset();
    set_ops(0, 2'd0, 2'd1);
    set_ops(1, 2'd2, 2'd2);
    set_ops(2, 2'd3, 2'd0);
    set_ops(3, 2'd1, 2'd3);
    rr_ids[0] = 2'd0; rr_ids[1] = 2'd1; rr_ids[2] = 2'd2; rr_ids[3] = 2'd3; rr_ids[4] = 2'd0;
    push_exp(0, 1'b0, 1'b0, 1'b1);
    push_exp(1, 1'b0, 1'b1, 1'b0);
    push_exp(2, 1'b1, 1'b0, 1'b0);
    push_exp(3, 1'b0, 1'b0, 1'b1);
    push_exp(0, 1'b0, 1'b0, 1'b1);
    req    = 4'b1111;
    prev_c = 0;
    for (int k = 0; k < 5; k++) begin
      wait_done(id, c);
      check("rr_order", 32'(id), 32'(rr_ids[k]));
      if (k > 0) begin
        check("rr_spacing", 32'(c - prev_c), 32'd3);
      end
      prev_c = c;
    end
    req = '0;

    // Fairness: req0 held, req3 joins -> 0, 3, 0.
    pulse_reset();
    set_ops(0, 2'd1, 2'd0);
    set_ops(3, 2'd0, 2'd2);
    push_exp(0, 1'b1, 1'b0, 1'b0);
    push_exp(3, 1'b0, 1'b0, 1'b1);
    push_exp(0, 1'b1, 1'b0, 1'b0);
    req[0] = 1'b1;
    @(negedge clk);
    req[3] = 1'b1;
    wait_done(id, c);
    check("fair_first", 32'(id), 32'd0);
    wait_done(id, c);
    check("fair_second", 32'(id), 32'd3);
    req[3] = 1'b0;
    wait_done(id, c);
    check("fair_third", 32'(id), 32'd0);
    req[0] = 1'b0;

    // Operands and req change during EVAL; latched values win.
    repeat (2) @(negedge clk);
    set_ops(2, 2'd2, 2'd3);
    push_exp(2, 1'b0, 1'b0, 1'b1);
    req[2] = 1'b1;
    @(negedge clk);
    set_ops(2, 2'd3, 2'd0);
    req = '0;
    wait_done(id, c);
    check("stable_id", 32'(id), 32'd2);
    repeat (6) @(negedge clk);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1);
  end

endmodule
